// File: rtl/sprite_blitter_pkg.sv
// Shared types and constants for the sprite blitter.
// Latency: none (types and constants only).
// Backpressure: none.
`include "blitter.vh"

package sprite_blitter_pkg;

    localparam logic [2:0] OP_CLEAR     = `BLIT_OP_CLEAR;
    localparam logic [2:0] OP_SPRITE    = `BLIT_OP_SPRITE;
    localparam logic [2:0] OP_SPRITE_16 = `BLIT_OP_SPRITE_16;

    // Geometry sized to the arithmetic widths used by the datapath.
    localparam logic [4:0] FB_COLS = 5'(`FB_COLS);
    localparam logic [6:0] FB_ROWS = 7'(`FB_ROWS);
    localparam logic [9:0] FB_LAST = 10'(`FB_BYTES - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_SPR_ISSUE,
        ST_SPR_WAIT,
        ST_SPR_CAP,
        ST_FB_ISSUE,
        ST_FB_WAIT,
        ST_FB_WR,
        ST_DONE
    } state_t;

    // One captured blit request; field order matches the port concatenation.
    typedef struct packed {
        logic [2:0]  op;
        logic [11:0] src;
        logic [3:0]  height;
        logic [6:0]  x;
        logic [5:0]  y;
    } req_t;

    // Framebuffer byte address: row-major, 16 bytes per pixel row.
    function automatic logic [9:0] fb_byte_addr(input logic [5:0] row, input logic [3:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/blitter.vh
// Op codes and framebuffer geometry shared between the CPU and the blitter.
// Pure macro header: no logic, so it costs nothing and needs no clock.
// Include guard allows multiple files of a build to pull it in.
`ifndef BLITTER_VH
`define BLITTER_VH

`define BLIT_OP_NOP        3'd0
`define BLIT_OP_CLEAR      3'd1
`define BLIT_OP_SPRITE     3'd2
`define BLIT_OP_SPRITE_16  3'd3

`define FB_COLS   16
`define FB_ROWS   64
`define FB_BYTES  1024

`endif

// File: rtl/sprite_blitter_row_shifter.sv
// Aligns a 16-bit sprite row to a pixel X offset, spreading it over 3 bytes.
// Latency: combinational.
// Backpressure: none.
module blit_row_shifter (
    input  logic [15:0] row,
    input  logic [2:0]  shift,
    output logic [7:0]  tgt0,
    output logic [7:0]  tgt1,
    output logic [7:0]  tgt2
);

    logic [23:0] spread;

    // MSB is the leftmost pixel, so moving right on screen is a right shift.
    always_comb begin
        spread = {row, 8'h00} >> shift;
        tgt0   = spread[23:16];
        tgt1   = spread[15:8];
        tgt2   = spread[7:0];
    end

endmodule

// File: rtl/sprite_blitter.sv
// CPU blit responder: CLEAR / SPRITE / SPRITE_16 XOR-blits into the 128x64 framebuffer.
// Latency fixed: 1025 cycles CLEAR, 2+9H SPRITE, 242 SPRITE_16 (clipped bytes keep their slots).
// No backpressure: one-deep pending slot, further requests while it is full are dropped.
// Optional feature macro BLIT_WRAP_EN: wrap off-screen bytes instead of clipping them.
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter logic [7:0] CLEAR_FILL = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  blit_op,
    input  logic [11:0] blit_src,
    input  logic [3:0]  blit_srcHeight,
    input  logic [6:0]  blit_destX,
    input  logic [5:0]  blit_destY,
    input  logic        blit_enable,
    output logic        blit_done,
    output logic        blit_collision,
    output logic        spr_en,
    output logic [11:0] spr_addr,
    input  logic [7:0]  spr_data,
    output logic        fb_en,
    output logic        fb_wr,
    output logic [9:0]  fb_addr,
    output logic [7:0]  fb_din,
    input  logic [7:0]  fb_dout
);

    state_t      state;
    req_t        cur;
    req_t        pend;
    logic        pend_vld;
    logic        enable_q;
    logic [3:0]  row;
    logic        sb;
    logic [1:0]  tgt;
    logic [15:0] row_dat;

    req_t        in_req;
    req_t        start_req;
    logic        start_edge;
    logic        take_pend;
    logic        take_edge;
    logic        is16;
    logic [3:0]  last_row;
    logic [1:0]  last_tgt;
    logic [11:0] spr_a;
    logic [7:0]  sh0;
    logic [7:0]  sh1;
    logic [7:0]  sh2;
    logic [7:0]  new_dat;
    logic [4:0]  tcol;
    logic [6:0]  trow;
    logic        tvld;
    logic [9:0]  taddr;

    assign in_req = {blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY};

    blit_row_shifter u_shift (
        .row   (row_dat),
        .shift (cur.x[2:0]),
        .tgt0  (sh0),
        .tgt1  (sh1),
        .tgt2  (sh2)
    );

    // Request arbitration, per-row geometry and target-byte addressing.
    always_comb begin
        start_edge = blit_enable & ~enable_q;
        // The pending request waits out the done-pulse cycle of the blit ahead.
        take_pend  = (state == ST_IDLE) && pend_vld && !blit_done;
        take_edge  = (state == ST_IDLE) && !pend_vld && start_edge;
        start_req  = take_pend ? pend : in_req;

        is16     = (cur.op == OP_SPRITE_16);
        last_row = is16 ? 4'd15 : (cur.height - 4'd1);
        last_tgt = is16 ? 2'd2 : 2'd1;
        spr_a    = is16 ? (cur.src + {7'd0, row, sb}) : (cur.src + {8'd0, row});

        case (tgt)
            2'd0:    new_dat = sh0;
            2'd1:    new_dat = sh1;
            default: new_dat = sh2;
        endcase

        tcol = {1'b0, cur.x[6:3]} + {3'd0, tgt};
        trow = {1'b0, cur.y} + {3'd0, row};
`ifdef BLIT_WRAP_EN
        tvld = 1'b1;
`else
        tvld = (tcol < FB_COLS) && (trow < FB_ROWS);
`endif
        taddr = fb_byte_addr(trow[5:0], tcol[3:0]);
    end

    // Rising-edge detection and the one-deep pending request slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= 1'b0;
            pend_vld <= 1'b0;
            pend     <= '0;
        end else begin
            enable_q <= blit_enable;
            if (take_pend) begin
                // Slot drains this cycle; a simultaneous new edge refills it.
                pend_vld <= start_edge;
                if (start_edge) begin
                    pend <= in_req;
                end
            end else if (start_edge && !take_edge && !pend_vld) begin
                pend_vld <= 1'b1;
                pend     <= in_req;
            end
        end
    end

    // Blit sequencer: RAM strobes, datapath captures and completion are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cur            <= '0;
            row            <= 4'd0;
            sb             <= 1'b0;
            tgt            <= 2'd0;
            row_dat        <= 16'h0000;
            blit_done      <= 1'b0;
            blit_collision <= 1'b0;
            spr_en         <= 1'b0;
            spr_addr       <= 12'h000;
            fb_en          <= 1'b0;
            fb_wr          <= 1'b0;
            fb_addr        <= 10'd0;
            fb_din         <= 8'h00;
        end else begin
            blit_done <= 1'b0;
            spr_en    <= 1'b0;
            fb_en     <= 1'b0;
            fb_wr     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take_pend || take_edge) begin
                        cur            <= start_req;
                        row            <= 4'd0;
                        sb             <= 1'b0;
                        tgt            <= 2'd0;
                        blit_collision <= 1'b0;
                        if (start_req.op == OP_CLEAR) begin
                            // First clear write goes out in cycle 1.
                            state   <= ST_CLR;
                            fb_en   <= 1'b1;
                            fb_wr   <= 1'b1;
                            fb_addr <= 10'd0;
                            fb_din  <= CLEAR_FILL;
                        end else if ((start_req.op == OP_SPRITE && start_req.height != 4'd0) ||
                                     start_req.op == OP_SPRITE_16) begin
                            state <= ST_SPR_ISSUE;
                        end else begin
                            // Zero-height sprites and unknown ops complete with nothing drawn.
                            state <= ST_DONE;
                        end
                    end
                end
                ST_CLR: begin
                    if (fb_addr == FB_LAST) begin
                        // Done pulse directly follows the last write cycle.
                        blit_done <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        fb_en   <= 1'b1;
                        fb_wr   <= 1'b1;
                        fb_addr <= fb_addr + 10'd1;
                    end
                end
                ST_SPR_ISSUE: begin
                    spr_en   <= 1'b1;
                    spr_addr <= spr_a;
                    state    <= ST_SPR_WAIT;
                end
                ST_SPR_WAIT: begin
                    state <= ST_SPR_CAP;
                end
                ST_SPR_CAP: begin
                    if (is16 && !sb) begin
                        row_dat[15:8] <= spr_data;
                        sb            <= 1'b1;
                        state         <= ST_SPR_ISSUE;
                    end else begin
                        if (is16) begin
                            row_dat[7:0] <= spr_data;
                        end else begin
                            row_dat <= {spr_data, 8'h00};
                        end
                        tgt   <= 2'd0;
                        state <= ST_FB_ISSUE;
                    end
                end
                ST_FB_ISSUE: begin
                    // Clipped bytes keep their slot with the enable held low.
                    fb_en   <= tvld;
                    fb_addr <= taddr;
                    state   <= ST_FB_WAIT;
                end
                ST_FB_WAIT: begin
                    state <= ST_FB_WR;
                end
                ST_FB_WR: begin
                    fb_en  <= tvld;
                    fb_wr  <= tvld;
                    fb_din <= fb_dout ^ new_dat;
                    if (tvld && ((fb_dout & new_dat) != 8'h00)) begin
                        blit_collision <= 1'b1;
                    end
                    if (tgt != last_tgt) begin
                        tgt   <= tgt + 2'd1;
                        state <= ST_FB_ISSUE;
                    end else if (row != last_row) begin
                        row   <= row + 4'd1;
                        sb    <= 1'b0;
                        state <= ST_SPR_ISSUE;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    blit_done <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
